key_reverse: RTL and testbench

KEY_REVERSE -- requirements
Module: key_reverse

---
 rtl/key_reverse_if.sv | 23 ++
 rtl/key_reverse.sv | 150 +++++++++++++++
 tb/tb_key_reverse.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/key_reverse_if.sv
// Request/response bundle for the AES-128 round-key reverser.
// start and next are single-cycle pulses sampled on the rising clock edge; start is
// accepted in IDLE or SERVE (start wins over next), next only in SERVE; no handshake back.
interface key_reverse_if;
    logic         start;
    logic [127:0] key;
    logic         next;
    logic         busy;
    logic         valid;
    logic [3:0]   round;
    logic [127:0] keyout;
    logic [1:0]   state;

    modport master (
        output start, key, next,
        input  busy, valid, round, keyout, state
    );

    modport slave (
        input  start, key, next,
        output busy, valid, round, keyout, state
    );
endinterface

// File: rtl/key_reverse.sv
// AES-128 key schedule: expands the cipher key forward to round 10 once, then walks
// back one round key per next pulse using the inverse schedule step.
module key_reverse (
    input  logic           clk,
    input  logic           rst_n,
    key_reverse_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        SERVE  = 2'd2
    } state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b sits (255-b) bytes up from the LSB; ~b is exactly 255-b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t        state_q;
    logic [127:0]  work_q;
    logic [127:0]  saved_k10_q;
    logic [3:0]    cnt_q;
    logic [3:0]    round_q;
    logic          busy_q;
    logic          valid_q;

    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   sb_in, rot_in, sb_out, temp;
    logic [3:0]    rc_idx;
    logic [127:0]  fwd_key, inv_key;

    assign w0 = work_q[127:96];
    assign w1 = work_q[95:64];
    assign w2 = work_q[63:32];
    assign w3 = work_q[31:0];

    // One shared SubWord(RotWord()) feeds both directions: forward uses w3,
    // inverse reconstructs the previous w3 as w3^w2.
    always_comb begin
        sb_in   = (state_q == SERVE) ? (w3 ^ w2) : w3;
        rc_idx  = (state_q == SERVE) ? (round_q - 4'd1) : cnt_q;
        rot_in  = {sb_in[23:0], sb_in[31:24]};
        sb_out  = {sbox(rot_in[31:24]), sbox(rot_in[23:16]),
                   sbox(rot_in[15:8]),  sbox(rot_in[7:0])};
        temp    = sb_out ^ {rcon(rc_idx), 24'h000000};
        fwd_key = {w0 ^ temp,
                   w1 ^ w0 ^ temp,
                   w2 ^ w1 ^ w0 ^ temp,
                   w3 ^ w2 ^ w1 ^ w0 ^ temp};
        inv_key = {w0 ^ temp, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            saved_k10_q <= '0;
            cnt_q       <= '0;
            round_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        work_q  <= bus.key;
                        cnt_q   <= '0;
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    work_q <= fwd_key;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        saved_k10_q <= fwd_key;
                        round_q     <= 4'd10;
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= SERVE;
                    end
                end
                SERVE: begin
                    if (bus.start) begin
                        work_q  <= bus.key;
                        cnt_q   <= '0;
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= EXPAND;
                    end else if (bus.next) begin
                        if (round_q == 4'd0) begin
                            work_q  <= saved_k10_q;
                            round_q <= 4'd10;
                        end else begin
                            work_q  <= inv_key;
                            round_q <= round_q - 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.round  = round_q;
    assign bus.keyout = work_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_key_reverse.sv
// Directed bench for key_reverse using FIPS-197 key schedules.
module tb_key_reverse;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z9  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    key_reverse_if bus ();

    key_reverse dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.next  = 1'b0;
        bus.key   = '0;
        #2;
        chk("rst_busy",   bus.busy,   0);
        chk("rst_valid",  bus.valid,  0);
        chk("rst_round",  bus.round,  0);
        chk("rst_keyout", bus.keyout, 0);
        chk("rst_state",  bus.state,  0);

        // first start accepted on the first edge after release
        #10;
        rst_n = 1'b1;
        bus.start = 1'b1;
        bus.key   = K1;
        tick();
        bus.start = 1'b0;
        chk("t0_busy",   bus.busy,   1);
        chk("t0_valid",  bus.valid,  0);
        chk("t0_keyout", bus.keyout, K1);
        chk("t0_state",  bus.state,  1);
        tick();
        chk("t1_keyout", bus.keyout, R1);
        chk("t1_busy",   bus.busy,   1);
        repeat (8) tick();
        chk("t9_busy",  bus.busy,  1);
        chk("t9_valid", bus.valid, 0);
        tick();
        chk("t10_busy",   bus.busy,   0);
        chk("t10_valid",  bus.valid,  1);
        chk("t10_round",  bus.round,  10);
        chk("t10_keyout", bus.keyout, R10);
        chk("t10_state",  bus.state,  2);

        // walk down to round 0, then wrap
        bus.next = 1'b1;
        tick();
        chk("n1_round",  bus.round,  9);
        chk("n1_keyout", bus.keyout, R9);
        repeat (8) tick();
        chk("n9_round",  bus.round,  1);
        chk("n9_keyout", bus.keyout, R1);
        tick();
        chk("n10_round",  bus.round,  0);
        chk("n10_keyout", bus.keyout, K1);
        tick();
        chk("wrap_round",  bus.round,  10);
        chk("wrap_keyout", bus.keyout, R10);
        chk("wrap_busy",   bus.busy,   0);
        bus.next = 1'b0;
        repeat (3) tick();
        chk("hold_round",  bus.round,  10);
        chk("hold_keyout", bus.keyout, R10);

        // restart; start(key=0) at cycle 4 and next at cycle 6 of expansion are ignored
        bus.start = 1'b1;
        bus.key   = K1;
        tick();
        bus.start = 1'b0;
        chk("rs_valid", bus.valid, 0);
        chk("rs_busy",  bus.busy,  1);
        for (int i = 1; i <= 10; i++) begin
            bus.start = (i == 4);
            bus.key   = '0;
            bus.next  = (i == 6);
            tick();
        end
        bus.start = 1'b0;
        bus.next  = 1'b0;
        chk("ign_valid",  bus.valid,  1);
        chk("ign_round",  bus.round,  10);
        chk("ign_keyout", bus.keyout, R10);

        // down to round 5 then async reset
        bus.next = 1'b1;
        repeat (5) tick();
        bus.next = 1'b0;
        chk("r5_round",  bus.round,  5);
        chk("r5_keyout", bus.keyout, R5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy",   bus.busy,   0);
        chk("ar_valid",  bus.valid,  0);
        chk("ar_round",  bus.round,  0);
        chk("ar_keyout", bus.keyout, 0);
        chk("ar_state",  bus.state,  0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.next = 1'b1;
        repeat (3) tick();
        bus.next = 1'b0;
        chk("pr_valid",  bus.valid,  0);
        chk("pr_round",  bus.round,  0);
        chk("pr_keyout", bus.keyout, 0);
        chk("pr_state",  bus.state,  0);

        // start and next together in SERVE: start wins
        bus.start = 1'b1;
        bus.key   = K1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("s2_keyout", bus.keyout, R10);
        bus.start = 1'b1;
        bus.next  = 1'b1;
        bus.key   = '0;
        tick();
        bus.start = 1'b0;
        bus.next  = 1'b0;
        chk("sn_valid",  bus.valid,  0);
        chk("sn_busy",   bus.busy,   1);
        chk("sn_keyout", bus.keyout, 0);
        repeat (10) tick();
        chk("z10_valid",  bus.valid,  1);
        chk("z10_round",  bus.round,  10);
        chk("z10_keyout", bus.keyout, Z10);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        chk("z9_round",  bus.round,  9);
        chk("z9_keyout", bus.keyout, Z9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
